// File: rtl/sliced_addsub.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair SLICE bits per clock,
// with the inter-slice carry held in a flop and a start/busy/done handshake.
module sliced_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("sliced_addsub: WIDTH must be a multiple of SLICE");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic [KW-1:0]    k;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] ssum;
   logic             scout;
   logic             smsb_cin;
   logic             last;

   // Ripple of full adders over the current slice; smsb_cin keeps the carry into
   // the slice MSB, which on the last slice is the carry into bit WIDTH-1.
   always_comb begin
      logic cy;
      sa       = opa[k*SLICE +: SLICE];
      sb       = opb[k*SLICE +: SLICE];
      ssum     = '0;
      cy       = carry;
      smsb_cin = carry;
      for (int unsigned i = 0; i < SLICE; i++) begin
         ssum[i]  = sa[i] ^ sb[i] ^ cy;
         smsb_cin = cy;
         cy       = (sa[i] & sb[i]) | (cy & (sa[i] ^ sb[i]));
      end
      scout = cy;
      last  = (k == KW'(NSLICE - 1));
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         carry    <= 1'b0;
         k        <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  opa      <= a;
                  opb      <= sub ? ~b : b;
                  carry    <= cin;
                  k        <= '0;
                  sum      <= '0;
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sum[k*SLICE +: SLICE] <= ssum;
               carry                 <= scout;
               k                     <= k + 1'b1;
               if (last) begin
                  cout     <= scout;
                  overflow <= smsb_cin ^ scout;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sliced_addsub.sv
// Directed bench for sliced_addsub: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented vectors, handshake and reset cases.
module tb_sliced_addsub;

   localparam int W  = 16;
   localparam int SL = 4;
   localparam int NS = W / SL;

   logic         clock = 1'b0;
   logic         resetn;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;

   logic [W-1:0] sum;
   logic         cout, overflow, busy, done;
   logic [W-1:0] sum1;
   logic         cout1, ovf1, busy1, done1;

   sliced_addsub #(.WIDTH(W), .SLICE(SL)) u0 (
      .clock(clock), .resetn(resetn), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
   );

   sliced_addsub #(.WIDTH(W), .SLICE(W)) u1 (
      .clock(clock), .resetn(resetn), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .sum(sum1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
   );

   always #5 clock = ~clock;

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: result from plain arithmetic, timing from the accept cycle.
   int           cyc   = 0;
   int           m_acc = -1000;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf  = 1'b0;
   logic [W-1:0] m_bb;
   logic [W:0]   m_t;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_acc  = -1000;
         m_sum  = '0;
         m_cout = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         cyc++;
         if (start && (cyc >= m_acc + NS + 1)) begin
            m_bb   = sub ? ~b : b;
            m_t    = {1'b0, a} + {1'b0, m_bb} + {{W{1'b0}}, cin};
            m_acc  = cyc;
            m_sum  = m_t[W-1:0];
            m_cout = m_t[W];
            m_ovf  = (a[W-1] == m_bb[W-1]) && (m_t[W-1] != a[W-1]);
         end
      end
   end

   int           ph;
   logic [W-1:0] pmask;

   always @(negedge clock) begin
      ph = cyc - m_acc;
      if (ph >= 0 && ph < NS) begin
         pmask = W'((32'h1 << (ph * SL)) - 1);
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_partial", sum, m_sum & pmask);
         chk("cout_run", cout, 0);
         chk("ovf_run", overflow, 0);
      end else begin
         chk("busy_idle", busy, 0);
         chk("done_pulse", done, (ph == NS) ? 1 : 0);
         chk("sum_hold", sum, m_sum);
         chk("cout_hold", cout, m_cout);
         chk("ovf_hold", overflow, m_ovf);
      end
   end

   task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                     input logic tc);
      @(negedge clock);
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("done_timeout", (n < 20) ? 1 : 0, 1);
   endtask

   task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic ts, input logic tc, input logic [W-1:0] es,
                     input logic ec, input logic eo);
      int n;
      go(ta, tb_, ts, tc);
      wait_done(n);
      chk({nm, "_latency"}, n, NS);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, cout, ec);
      chk({nm, "_ovf"}, overflow, eo);
   endtask

   initial begin
      int n, d1, ndone;
      resetn = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      #1 resetn = 1'b0;
      #1;
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;

      op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
      op("ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      op("sub1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op("sbb",    16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
      op("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op("ovfsub", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // start and operand changes during RUN must not disturb the running result
      go(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(n);
      chk("ign_sum", sum, 16'h2201);
      chk("ign_cout", cout, 0);
      chk("ign_ovf", overflow, 0);

      // back-to-back accept from the DONE cycle
      go(16'h0001, 16'h0002, 1'b0, 1'b0);
      wait_done(n);
      chk("b2b_first_sum", sum, 16'h0003);
      d1 = cyc;
      a = 16'h00F0; b = 16'h000F; sub = 1'b0; cin = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(n);
      chk("b2b_gap", cyc - d1, 5);
      chk("b2b_sum", sum, 16'h0100);

      // asynchronous reset between E2 and E3
      go(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1 chk("pre_rst_sum", sum, 16'h0001);
      #1 resetn = 1'b0;
      #1;
      chk("arst_sum", sum, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(posedge clock);
      #3 resetn = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      chk("post_rst_no_done", ndone, 0);
      op("recover", 16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0);

      // single-slice build: done in the cycle after E1
      go(16'hABCD, 16'h1111, 1'b0, 1'b0);
      chk("s1_done_e0", done1, 0);
      chk("s1_busy_e0", busy1, 1);
      @(negedge clock);
      chk("s1_done_e1", done1, 1);
      chk("s1_sum", sum1, 16'hBCDE);
      chk("s1_cout", cout1, 0);
      @(negedge clock);
      chk("s1_done_drop", done1, 0);
      chk("s1_hold", sum1, 16'hBCDE);
      wait_done(n);
      go(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      @(negedge clock);
      chk("s1_ovf_done", done1, 1);
      chk("s1_ovf_sum", sum1, 16'h8000);
      chk("s1_ovf", ovf1, 1);
      wait_done(n);
      @(negedge clock);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/sliced_addsub.md
Name: sliced_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the 4-bit combinational ripple-carry adder.
- Processes a WIDTH-bit operand pair SLICE bits per clock. Each slice is a ripple-carry chain; the inter-slice carry is held in a flop.
- Adds subtract mode, carry chaining, signed overflow and a start/busy/done handshake.
- Sits behind board-level switch/LED wrappers or a datapath controller where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits added per cycle. WIDTH must be a multiple of SLICE; any other value is an elaboration error.
- NSLICE (localparam), WIDTH/SLICE, number of compute cycles.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0: a+b+cin; 1: a+~b+cin (cin=1 gives plain subtract, cin=0 gives subtract-with-borrow)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (inverted borrow when sub=1)
- sum  output  WIDTH  result, registered
- cout  output  1  carry out of MSB (1 = no borrow when sub=1)
- overflow  output  1  signed overflow
- busy  output  1  high while computing
- done  output  1  one-cycle pulse when the result is valid

Behaviour:
- Reset (resetn=0, asynchronous, any state):
  - State goes to IDLE.
  - sum, cout, overflow, busy, done and the internal carry/slice counter all go to 0.
  - An in-flight operation is aborted and no done is produced for it.
- States are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge, accept it.
- Accept (edge E0, from IDLE or DONE):
  - Latch a into opA. Latch b, or ~b when sub=1, into opB.
  - Latch cin into the carry flop and set k=0.
  - Clear sum, cout and overflow.
  - Go to RUN with busy=1.
- RUN, at each edge E1..E_NSLICE:
  - sum[k*SLICE +: SLICE] = opA slice + opB slice + carry, computed as a SLICE-bit ripple of full adders.
  - The carry flop takes the slice carry-out, then k increments.
  - Only the slice being written changes. Other sum bits keep their cleared or previous-slice values.
- Last slice (k=NSLICE-1):
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Go to DONE.
- DONE, one cycle:
  - busy=0, done=1.
  - sum, cout and overflow are valid.
  - At the next edge, start=1 is accepted immediately (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at E0 gives done high in the cycle following E_NSLICE. Throughput is one result per NSLICE+1 cycles.
- Result hold: sum, cout and overflow hold their final values through DONE and IDLE until the next accepted start.
- start while in RUN is ignored. It is not queued.
- a, b, sub and cin are used only at accept. Changes during RUN have no effect.
- NSLICE=1 (SLICE=WIDTH): RUN lasts one cycle, so done is high in the cycle following E1.
- Reset released mid-cycle: the block resumes in IDLE. No spurious done.

Test Plan:
- WIDTH=16, SLICE=4: a=0x1234, b=0x0FCD, cin=0, sub=0, start at E0 -> busy for E1..E4; done one cycle after E4; sum=0x2201, cout=0, overflow=0.
- Full ripple: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, overflow=0. Confirms the carry crosses all 4 slice boundaries.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, overflow=0.
  - a=0x0007, b=0x0005, sub=1, cin=0 -> sum=0x0001, cout=1.
- Overflow:
  - a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, cout=0, overflow=1.
  - a=0x8000, b=0x0001, sub=1, cin=1 -> sum=0x7FFF, cout=1, overflow=1.
- Handshake:
  - start pulsed again at E2, and a/b changed during RUN -> ignored; first result is unchanged.
  - start held high in the DONE cycle -> accepted; second done arrives exactly 5 cycles after the first.
  - SLICE=16 build -> done one cycle after E1.
- Reset: resetn driven low between E2 and E3 of an operation -> sum=0, busy=0, done=0 immediately (asynchronous). After release, state is IDLE and no done appears until a new start.
